// File: rtl/countdown_timer_bcd_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer: FSM encoding,
// digit limits and the load-word validity check.
package countdown_timer_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam int SEC_TENS_MAX = 5;
   localparam int ONES_MAX     = 9;
   localparam int MIN_TENS_MAX = 5;
   localparam int LOAD_W       = 14;

   // Load word layout: {min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]}
   function automatic logic bcd_valid(input logic [LOAD_W-1:0] d);
      return (d[13:11] <= 3'(MIN_TENS_MAX)) && (d[10:7] <= 4'(ONES_MAX)) &&
             (d[6:4]   <= 3'(SEC_TENS_MAX)) && (d[3:0]  <= 4'(ONES_MAX));
   endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Command and status bundle of the countdown timer; the controller drives
// the master side, the timer implements the slave side.
interface countdown_timer_bcd_if;
   import countdown_timer_bcd_pkg::*;

   logic              load;
   logic [LOAD_W-1:0] load_data;
   logic              start;
   logic              pause;
   logic [2:0]        min_tens;
   logic [3:0]        min_ones;
   logic [2:0]        sec_tens;
   logic [3:0]        sec_ones;
   logic [1:0]        state;
   logic              done;
   logic              alarm;
   logic              load_err;

   modport master (
      output load, load_data, start, pause,
      input  min_tens, min_ones, sec_tens, sec_ones, state, done, alarm, load_err
   );

   modport slave (
      input  load, load_data, start, pause,
      output min_tens, min_ones, sec_tens, sec_ones, state, done, alarm, load_err
   );

endinterface

// File: rtl/countdown_timer_bcd_digit.sv
// One BCD digit of the countdown: modulo-M down counter with synchronous
// clear and load; borrow_out fires when a decrement wraps it from 0.
module bcd_digit_down #(
   parameter int W = 4,
   parameter int M = 10
) (
   input  logic         clk,
   input  logic         sclr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec_in,
   output logic [W-1:0] q,
   output logic         borrow_out
);

   localparam logic [W-1:0] TOP = W'(M - 1);
   localparam logic [W-1:0] ONE = W'(1);

   assign borrow_out = dec_in && (q == '0);

   // NOTE: state registers use <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (sclr)
         q <= '0;
      else if (load)
         q <= load_val;
      else if (dec_in)
         q <= (q == '0) ? TOP : q - ONE;
   end

endmodule

// File: rtl/countdown_timer_bcd.sv
// MM:SS countdown timer: prescaler and run/pause/expire FSM in this module,
// four chained bcd_digit_down instances hold the count.
module countdown_timer_bcd
   import countdown_timer_bcd_pkg::*;
#(
   parameter int TICK_DIV = 500000
) (
   input logic                  clk,
   input logic                  sclr,
   countdown_timer_bcd_if.slave bus
);

   localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);

   state_t        state_q, state_nxt;
   logic [PW-1:0] presc_q, presc_nxt;
   logic          done_q, alarm_q, load_err_q;
   logic          tick, load_ok, load_bad;

   logic [2:0] mt_q, st_q;
   logic [3:0] mo_q, so_q;
   logic       so_borrow, st_borrow, mo_borrow, mt_borrow_unused;
   logic       count_zero, count_one;

   assign count_zero = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == '0);
   assign count_one  = (mt_q == '0) && (mo_q == '0) && (st_q == '0) && (so_q == 4'd1);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state_q;
      presc_nxt = presc_q;
      tick      = 1'b0;
      load_ok   = 1'b0;
      load_bad  = 1'b0;
      if (bus.load && state_q != ST_RUN) begin
         if (bcd_valid(bus.load_data)) begin
            load_ok   = 1'b1;
            state_nxt = ST_IDLE;
            presc_nxt = '0;
         end else begin
            load_bad = 1'b1;
         end
      end else begin
         // A load while running is ignored, so lower-priority inputs still act.
         case (state_q)
            ST_IDLE: if (bus.start && !count_zero) begin
               state_nxt = ST_RUN;
               presc_nxt = '0;
            end
            ST_RUN: if (bus.pause) begin
               state_nxt = ST_PAUSE;
            end else if (presc_q == PRESC_LAST) begin
               tick      = 1'b1;
               presc_nxt = '0;
               if (count_one) state_nxt = ST_EXPIRED;
            end else begin
               presc_nxt = presc_q + PRESC_ONE;
            end
            ST_PAUSE:   if (bus.start) state_nxt = ST_RUN;
            ST_EXPIRED: if (bus.start) state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         done_q     <= 1'b0;
         alarm_q    <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         presc_q    <= presc_nxt;
         done_q     <= tick && count_one;
         alarm_q    <= (state_nxt == ST_EXPIRED);
         load_err_q <= load_bad;
      end
   end

   bcd_digit_down #(.W(4), .M(ONES_MAX + 1)) u_sec_ones (
      .clk(clk), .sclr(sclr), .load(load_ok), .load_val(bus.load_data[3:0]),
      .dec_in(tick), .q(so_q), .borrow_out(so_borrow)
   );

   bcd_digit_down #(.W(3), .M(SEC_TENS_MAX + 1)) u_sec_tens (
      .clk(clk), .sclr(sclr), .load(load_ok), .load_val(bus.load_data[6:4]),
      .dec_in(so_borrow), .q(st_q), .borrow_out(st_borrow)
   );

   bcd_digit_down #(.W(4), .M(ONES_MAX + 1)) u_min_ones (
      .clk(clk), .sclr(sclr), .load(load_ok), .load_val(bus.load_data[10:7]),
      .dec_in(st_borrow), .q(mo_q), .borrow_out(mo_borrow)
   );

   // Expiry stops the chain at 00:00, so the top digit never borrows.
   bcd_digit_down #(.W(3), .M(MIN_TENS_MAX + 1)) u_min_tens (
      .clk(clk), .sclr(sclr), .load(load_ok), .load_val(bus.load_data[13:11]),
      .dec_in(mo_borrow), .q(mt_q), .borrow_out(mt_borrow_unused)
   );

   assign bus.min_tens = mt_q;
   assign bus.min_ones = mo_q;
   assign bus.sec_tens = st_q;
   assign bus.sec_ones = so_q;
   assign bus.state    = state_q;
   assign bus.done     = done_q;
   assign bus.alarm    = alarm_q;
   assign bus.load_err = load_err_q;

endmodule

// File: doc/countdown_timer_bcd.md
COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning clk cycles per count-down step (min 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port sclr, input, 1, synchronous active-high reset.
REQ-004 SHALL have port load, input, 1, capture load_data this cycle.
REQ-005 SHALL have port load_data, input, 14, BCD MM:SS as {min_tens[2:0], min_ones[3:0], sec_tens[2:0], sec_ones[3:0]}.
REQ-006 SHALL have port start, input, 1, run / resume request.
REQ-007 SHALL have port pause, input, 1, pause request.
REQ-008 SHALL have ports min_tens (3), min_ones (4), sec_tens (3), sec_ones (4), all outputs, the current count in BCD.
REQ-009 SHALL have port state, output, 2: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse on expiry.
REQ-011 SHALL have port alarm, output, 1, high while in EXPIRED.
REQ-012 SHALL have port load_err, output, 1, a one-cycle pulse when a load is rejected.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Input priority SHALL be: sclr > load > pause > start > internal tick.
REQ-015 Load validity: min_tens<=5, min_ones<=9, sec_tens<=5, sec_ones<=9.
REQ-016 An invalid load SHALL leave count and state unchanged and pulse load_err in the next cycle.
REQ-017 A valid load in IDLE, PAUSE or EXPIRED SHALL set count=load_data, state=IDLE, prescaler=0, alarm=0.
REQ-018 load in RUN SHALL be ignored, with no load_err.
REQ-019 In IDLE, start with count!=00:00 SHALL go to RUN with prescaler=0; start with count==00:00 SHALL stay in IDLE.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 only in RUN; a tick is the RUN cycle with prescaler==TICK_DIV-1, after which the prescaler wraps to 0.
REQ-021 On tick, count SHALL decrement by one second with a borrow chain:
- sec_ones 0->9 borrows;
- sec_tens 0->5 borrows;
- min_ones 0->9 borrows;
- min_tens decrements.
REQ-022 The first decrement SHALL appear TICK_DIV cycles after the edge that entered RUN.
REQ-023 A tick producing 00:00 SHALL, at the same edge, set state=EXPIRED and done=1 for exactly one cycle.
REQ-024 In EXPIRED, alarm SHALL be 1 and count SHALL hold 00:00.
REQ-025 start in EXPIRED SHALL go to IDLE with alarm=0.
REQ-026 pause in RUN SHALL go to PAUSE with the prescaler value held; a coincident tick SHALL be suppressed (no decrement).
REQ-027 start in PAUSE SHALL return to RUN, resuming the held prescaler value.
REQ-028 pause outside RUN SHALL be ignored.
REQ-029 start and pause SHALL be level-sampled each cycle, with no edge detection.
REQ-030 No state SHALL ever present a BCD digit outside its modulo range.

Reset
REQ-031 sclr SHALL set count=00:00, state=IDLE, prescaler=0, done=0, alarm=0 and load_err=0 at the next edge, overriding all inputs in any state, including mid-RUN and on a tick cycle.

Structure
REQ-032 A shared package SHALL hold the state encoding constants and digit limits (SEC_TENS_MAX=5, ONES_MAX=9, MIN_TENS_MAX=5).
REQ-033 The block SHALL instantiate one sub-module, bcd_digit_down: a parameterised modulo-M down counter with dec_in, borrow_out and a synchronous load, used four times in a borrow chain.
REQ-034 The prescaler and FSM SHALL live in the top module.

Verification (TICK_DIV=4)
REQ-035 Basic countdown: load 00:03, start -> decrements at cycles 4, 8 and 12 after start; at 00:00, done pulses once, alarm=1, state=EXPIRED.
REQ-036 Borrow chain: load 10:00, start -> after one tick reads 09:59; load 01:00 -> after one tick reads 00:59.
REQ-037 Pause/resume: load 00:05, start, pause asserted on a tick cycle -> no decrement and state=PAUSE; start -> next tick arrives after the remaining held prescaler cycles.
REQ-038 Invalid load: load 00:6A (sec_tens=6) in IDLE -> count unchanged, load_err pulses once; load during RUN -> ignored, no load_err.
REQ-039 Reset mid-run: sclr on a tick cycle at 00:01 -> 00:00, IDLE, done=0, alarm=0.
REQ-040 Zero start: start at 00:00 in IDLE -> state stays IDLE, done never asserts.
